// File: rtl/fp8_rand_bits.sv
// Purpose: 16-bit Galois LFSR packs one bit per cycle into FP8 bit patterns for the converter.
// Latency: first word valid 8 edges after start is sampled; one word per 9 cycles with ready high.
// Backpressure: word held stable in PRESENT until out_ready; LFSR frozen while waiting.
module fp8_rand_bits #(
  parameter logic [15:0] TAPS         = 16'hB400,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        start,
  input  logic [7:0]  count,
  input  logic        abort,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [7:0]  bit_rep,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GEN     = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] lfsr;
  logic [15:0] lfsr_step;
  logic        out_bit;
  logic [7:0]  pack;
  logic [2:0]  bit_cnt;
  logic [7:0]  remaining;
  logic        cont;

  assign out_bit   = lfsr[0];
  assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);

  // Status flags decode directly from the state so done and busy can never overlap.
  assign busy = (state == GEN) || (state == PRESENT);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = GEN;
      GEN:     if (bit_cnt == 3'd7) state_nxt = PRESENT;
      PRESENT: begin
        if (out_ready) begin
          if (!cont && (remaining == 8'd1)) state_nxt = DONE;
          else                              state_nxt = GEN;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Datapath: LFSR, byte packing, word register and run counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr      <= DEFAULT_SEED;
      pack      <= 8'h00;
      bit_cnt   <= 3'd0;
      remaining <= 8'd0;
      cont      <= 1'b0;
      bit_rep   <= 8'h00;
      out_valid <= 1'b0;
    end else if (abort) begin
      // LFSR deliberately untouched so the next run continues the sequence.
      out_valid <= 1'b0;
      bit_cnt   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (seed_load) lfsr <= (seed == 16'h0000) ? DEFAULT_SEED : seed;
          if (start) begin
            remaining <= count;
            cont      <= (count == 8'd0);
            bit_cnt   <= 3'd0;
          end
        end
        GEN: begin
          lfsr    <= lfsr_step;
          pack    <= {pack[6:0], out_bit};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            bit_rep   <= {pack[6:0], out_bit};
            out_valid <= 1'b1;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!cont) remaining <= remaining - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_rand_bits.sv
// Directed bench for fp8_rand_bits with hand-computed LFSR words.
module tb_fp8_rand_bits;

  logic        clk;
  logic        rst_n;
  logic        seed_load;
  logic [15:0] seed;
  logic        start;
  logic [7:0]  count;
  logic        abort;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  bit_rep;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  fp8_rand_bits dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed      (seed),
    .start     (start),
    .count     (count),
    .abort     (abort),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .bit_rep   (bit_rep),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference LFSR: returns {lfsr_after, packed_byte} after nsteps steps.
  function automatic logic [23:0] model_run(input logic [15:0] s, input int nsteps);
    logic [15:0] l;
    logic [7:0]  b;
    l = s;
    b = 8'h00;
    for (int i = 0; i < nsteps; i++) begin
      b = {b[6:0], l[0]};
      if (l[0]) l = (l >> 1) ^ 16'hB400;
      else      l = l >> 1;
    end
    return {l, b};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; seed_load = 1'b0; seed = 16'h0; start = 1'b0;
    count = 8'd0; abort = 1'b0; out_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (bit_rep !== 8'h00) begin n_err++; $display("FAIL reset_bit_rep: got %h want 00", bit_rep); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (dut.lfsr !== 16'hACE1) begin n_err++; $display("FAIL reset_lfsr: got %h want ACE1", dut.lfsr); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    seed_load = 1'b1; seed = 16'h0001;
    tick();
    seed_load = 1'b0;
    n_cmp++; if (dut.lfsr !== 16'h0001) begin n_err++; $display("FAIL single_seed: got %h want 0001", dut.lfsr); end
    start = 1'b1; count = 8'd1; out_ready = 1'b1;
    tick();  // E0
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
    for (int i = 1; i <= 7; i++) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b want 0 after E7", out_valid); end
    tick();  // E8
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1 after E8", out_valid); end
    n_cmp++; if (bit_rep !== 8'h80) begin n_err++; $display("FAIL single_word: got %h want 80", bit_rep); end
    n_cmp++; if (dut.lfsr !== 16'h0168) begin n_err++; $display("FAIL single_lfsr: got %h want 0168", dut.lfsr); end
    tick();  // transfer
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL single_done: got %b want 1", done); end
    n_cmp++; if ({out_valid, busy} !== 2'b00) begin n_err++; $display("FAIL single_after_xfer: got valid,busy=%b want 00", {out_valid, busy}); end
    tick();
    n_cmp++; if ({done, busy} !== 2'b00) begin n_err++; $display("FAIL single_idle: got done,busy=%b want 00", {done, busy}); end
  endtask

  task automatic test_two_word();
    logic [7:0] got [0:3];
    int nw;
    int nd;
    nw = 0; nd = 0;
    // Seed load and start in the same cycle: the run must use the new seed.
    seed_load = 1'b1; seed = 16'h0001; start = 1'b1; count = 8'd2; out_ready = 1'b1;
    tick();
    seed_load = 1'b0; start = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (out_valid && nw < 4) begin got[nw] = bit_rep; nw++; end
      if (done) nd++;
    end
    n_cmp++; if (nw !== 2) begin n_err++; $display("FAIL two_count: got %0d words want 2", nw); end
    n_cmp++; if (got[0] !== 8'h80) begin n_err++; $display("FAIL two_word0: got %h want 80", got[0]); end
    n_cmp++; if (got[1] !== 8'h16) begin n_err++; $display("FAIL two_word1: got %h want 16", got[1]); end
    n_cmp++; if (nd !== 1) begin n_err++; $display("FAIL two_done: got %0d pulses want 1", nd); end
    n_cmp++; if (dut.lfsr !== 16'h7C41) begin n_err++; $display("FAIL two_lfsr: got %h want 7C41", dut.lfsr); end
  endtask

  task automatic test_back_pressure();
    seed_load = 1'b1; seed = 16'h0001;
    tick();
    seed_load = 1'b0;
    start = 1'b1; count = 8'd2; out_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20 && !out_valid; c++) tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_first_valid: got %b want 1", out_valid); end
    for (int c = 0; c < 20; c++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid: got %b want 1 cycle %0d", out_valid, c); end
      n_cmp++; if (bit_rep !== 8'h80) begin n_err++; $display("FAIL bp_hold_word: got %h want 80 cycle %0d", bit_rep, c); end
      n_cmp++; if (dut.lfsr !== 16'h0168) begin n_err++; $display("FAIL bp_hold_lfsr: got %h want 0168 cycle %0d", dut.lfsr, c); end
    end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drop: got %b want 0", out_valid); end
    for (int c = 0; c < 20 && !out_valid; c++) tick();
    n_cmp++; if (bit_rep !== 8'h16 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_second: got %h valid %b want 16 valid 1", bit_rep, out_valid); end
    tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL bp_done: got %b want 1", done); end
    tick();
  endtask

  task automatic test_zero_seed();
    int nd;
    nd = 0;
    seed_load = 1'b1; seed = 16'h0000;
    tick();
    seed_load = 1'b0;
    n_cmp++; if (dut.lfsr !== 16'hACE1) begin n_err++; $display("FAIL zero_seed: got %h want ACE1", dut.lfsr); end
    start = 1'b1; count = 8'd1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    // Start and seed_load mid-GEN must be ignored.
    start = 1'b1; count = 8'd5; seed_load = 1'b1; seed = 16'h1234;
    tick();
    start = 1'b0; seed_load = 1'b0; count = 8'd0;
    for (int c = 0; c < 20 && !out_valid; c++) tick();
    n_cmp++; if (bit_rep !== 8'h87 || out_valid !== 1'b1) begin n_err++; $display("FAIL zero_word: got %h valid %b want 87 valid 1", bit_rep, out_valid); end
    n_cmp++; if (dut.lfsr !== 16'hC2C4) begin n_err++; $display("FAIL zero_lfsr: got %h want C2C4", dut.lfsr); end
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done) nd++;
    end
    n_cmp++; if (nd !== 1 || busy !== 1'b0) begin n_err++; $display("FAIL zero_single_run: got %0d done busy %b want 1 done busy 0", nd, busy); end
  endtask

  task automatic test_continuous_abort();
    logic [7:0]  exp_w [0:3];
    logic [7:0]  got   [0:3];
    logic [23:0] r;
    logic [15:0] exp_l;
    logic [15:0] exp_abort;
    int nw;
    int nd;
    nw = 0; nd = 0;
    exp_l = 16'hC2C4;
    for (int k = 0; k < 4; k++) begin
      r = model_run(exp_l, 8);
      exp_w[k] = r[7:0];
      exp_l = r[23:8];
    end
    r = model_run(exp_l, 4);
    exp_abort = r[23:8];
    start = 1'b1; count = 8'd0; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 60 && nw < 4; c++) begin
      tick();
      if (out_valid) begin got[nw] = bit_rep; nw++; end
      if (done) nd++;
    end
    n_cmp++; if (nw !== 4) begin n_err++; $display("FAIL cont_count: got %0d words want 4", nw); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (got[k] !== exp_w[k]) begin n_err++; $display("FAIL cont_word%0d: got %h want %h", k, got[k], exp_w[k]); end
    end
    tick();  // 4th transfer
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done) nd++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if ({busy, out_valid, done} !== 3'b000) begin n_err++; $display("FAIL cont_abort_state: got busy,valid,done=%b want 000", {busy, out_valid, done}); end
    n_cmp++; if (dut.lfsr !== exp_abort) begin n_err++; $display("FAIL cont_abort_lfsr: got %h want %h", dut.lfsr, exp_abort); end
    tick();
    if (done) nd++;
    n_cmp++; if (nd !== 0) begin n_err++; $display("FAIL cont_no_done: got %0d pulses want 0", nd); end
    // Restart continues from the preserved LFSR value.
    r = model_run(exp_abort, 8);
    start = 1'b1; count = 8'd1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20 && !out_valid; c++) tick();
    n_cmp++; if (bit_rep !== r[7:0] || out_valid !== 1'b1) begin n_err++; $display("FAIL cont_restart: got %h valid %b want %h valid 1", bit_rep, out_valid, r[7:0]); end
    tick(); tick();
  endtask

  task automatic test_reset_mid_present();
    seed_load = 1'b1; seed = 16'h0001;
    tick();
    seed_load = 1'b0;
    start = 1'b1; count = 8'd1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20 && !out_valid; c++) tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rstp_reach_present: got %b want 1", out_valid); end
    rst_n = 1'b0;
    tick();
    n_cmp++; if ({out_valid, busy, done} !== 3'b000) begin n_err++; $display("FAIL rstp_flags: got valid,busy,done=%b want 000", {out_valid, busy, done}); end
    n_cmp++; if (bit_rep !== 8'h00) begin n_err++; $display("FAIL rstp_bit_rep: got %h want 00", bit_rep); end
    n_cmp++; if (dut.lfsr !== 16'hACE1) begin n_err++; $display("FAIL rstp_lfsr: got %h want ACE1", dut.lfsr); end
    n_cmp++; if (dut.pack !== 8'h00) begin n_err++; $display("FAIL rstp_pack: got %h want 00", dut.pack); end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_two_word();
    test_back_pressure();
    test_zero_seed();
    test_continuous_abort();
    test_reset_mid_present();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
